// File: rtl/nrisc_pkg.sv
// Shared nRISC control definitions: opcodes, FSM state codes, mux select codes
// and the control-word layout driven by the multicycle controller.
package nrisc_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_ARITH = 3'b000;
  localparam logic [OP_W-1:0] OP_LOGIC = 3'b001;
  localparam logic [OP_W-1:0] OP_LW    = 3'b010;
  localparam logic [OP_W-1:0] OP_SW    = 3'b011;
  localparam logic [OP_W-1:0] OP_BEQ   = 3'b100;
  localparam logic [OP_W-1:0] OP_J     = 3'b101;
  localparam logic [OP_W-1:0] OP_RSVD  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

  localparam logic [ST_W-1:0] S_INIT     = 4'd0;
  localparam logic [ST_W-1:0] S_FETCH    = 4'd1;
  localparam logic [ST_W-1:0] S_DECODE   = 4'd2;
  localparam logic [ST_W-1:0] S_EXEC_R   = 4'd3;
  localparam logic [ST_W-1:0] S_WB_R     = 4'd4;
  localparam logic [ST_W-1:0] S_MEM_ADDR = 4'd5;
  localparam logic [ST_W-1:0] S_MEM_RD   = 4'd6;
  localparam logic [ST_W-1:0] S_MEM_WB   = 4'd7;
  localparam logic [ST_W-1:0] S_MEM_WR   = 4'd8;
  localparam logic [ST_W-1:0] S_BRANCH   = 4'd9;
  localparam logic [ST_W-1:0] S_JUMP     = 4'd10;
  localparam logic [ST_W-1:0] S_HALT     = 4'd11;

  localparam logic [SEL_W-1:0] ULAOP_ARITH   = 2'b00;
  localparam logic [SEL_W-1:0] ULAOP_LOGIC   = 2'b01;
  localparam logic [SEL_W-1:0] ULAOP_ADD     = 2'b10;
  localparam logic [SEL_W-1:0] ULAOP_ADD_MEM = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_REG = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_ONE = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_BR  = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             ula_src_a;
    logic [SEL_W-1:0] ula_src_b;
    logic [SEL_W-1:0] ula_op;
    logic             forca_sub;
    logic [SEL_W-1:0] pc_source;
    logic             halted;
    logic             ilegal;
  } ctrl_t;

  // States that wait on the memory handshake and feed the timeout counter.
  function automatic logic is_mem_state(input logic [ST_W-1:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/controle_multiciclo_contador_espera.sv
// Saturating wait counter for memory handshakes; tc_o flags WAIT_MAX reached.
module contador_espera #(
  parameter int unsigned CW       = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(WAIT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the nRISC datapath: sequences each instruction and
// decodes the per-state datapath enables; halts on HALT or memory timeout.
module controle_multiciclo
  import nrisc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [1:0] ULAOp,
  output logic       ForcaSub,
  output logic [1:0] PCSource,
  output logic       Halted,
  output logic       Erro,
  output logic       Ilegal,
  output logic [3:0] Estado
);

  logic [ST_W-1:0] state_q, state_d;
  logic            erro_q, erro_d;
  logic            tc;
  logic            wait_c;
  logic            timeout_c;
  ctrl_t           ctrl_c;

  // Zero is consumed by the datapath's PCWriteCond gate, not by the FSM.
  logic unused_zero;
  assign unused_zero = Zero;

  assign wait_c    = is_mem_state(state_q) && !mem_ready;
  assign timeout_c = wait_c && tc;

  contador_espera #(
    .CW       (CW),
    .WAIT_MAX (WAIT_MAX)
  ) u_contador_espera (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_d != state_q),
    .en_i  (wait_c),
    .tc_o  (tc)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    erro_d  = erro_q | timeout_c;
    case (state_q)
      S_INIT:     state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (tc)        state_d = S_HALT;
      end
      S_DECODE: begin
        case (Opcode)
          OP_ARITH, OP_LOGIC: state_d = S_EXEC_R;
          OP_LW, OP_SW:       state_d = S_MEM_ADDR;
          OP_BEQ:             state_d = S_BRANCH;
          OP_J:               state_d = S_JUMP;
          OP_HALT:            state_d = S_HALT;
          OP_RSVD:            state_d = S_FETCH;
          default:            state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)      state_d = S_MEM_WB;
        else if (tc)        state_d = S_HALT;
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (tc)        state_d = S_HALT;
      end
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      erro_q  <= erro_d;
    end
  end

  // Output decode from the state register; FETCH loads and Ilegal are gated
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.iord      = 1'b0;
        ctrl_c.ula_src_a = 1'b0;
        ctrl_c.ula_src_b = SRCB_ONE;
        ctrl_c.ula_op    = ULAOP_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.ula_src_a = 1'b0;
        ctrl_c.ula_src_b = SRCB_BR;
        ctrl_c.ula_op    = ULAOP_ADD;
        ctrl_c.ilegal    = (Opcode == OP_RSVD);
      end
      S_EXEC_R: begin
        ctrl_c.ula_src_a = 1'b1;
        ctrl_c.ula_src_b = SRCB_REG;
        ctrl_c.ula_op    = Opcode[0] ? ULAOP_LOGIC : ULAOP_ARITH;
      end
      S_WB_R: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b0;
      end
      S_MEM_ADDR: begin
        ctrl_c.ula_src_a = 1'b1;
        ctrl_c.ula_src_b = SRCB_IMM;
        ctrl_c.ula_op    = ULAOP_ADD_MEM;
      end
      S_MEM_RD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.ula_src_a     = 1'b1;
        ctrl_c.ula_src_b     = SRCB_REG;
        ctrl_c.ula_op        = ULAOP_ARITH;
        ctrl_c.forca_sub     = 1'b1;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ULAOUT;
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
      end
      S_HALT:  ctrl_c.halted = 1'b1;
      default: ctrl_c = '0;
    endcase
  end

  assign PCWrite     = ctrl_c.pc_write;
  assign PCWriteCond = ctrl_c.pc_write_cond;
  assign IorD        = ctrl_c.iord;
  assign MemRead     = ctrl_c.mem_read;
  assign MemWrite    = ctrl_c.mem_write;
  assign IRWrite     = ctrl_c.ir_write;
  assign RegWrite    = ctrl_c.reg_write;
  assign MemtoReg    = ctrl_c.mem_to_reg;
  assign ULASrcA     = ctrl_c.ula_src_a;
  assign ULASrcB     = ctrl_c.ula_src_b;
  assign ULAOp       = ctrl_c.ula_op;
  assign ForcaSub    = ctrl_c.forca_sub;
  assign PCSource    = ctrl_c.pc_source;
  assign Halted      = ctrl_c.halted;
  assign Ilegal      = ctrl_c.ilegal;
  assign Erro        = erro_q;
  assign Estado      = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed scoreboard bench for controle_multiciclo: each cycle's expected
// control word is queued when inputs are driven and compared mid-cycle.
module tb_controle_multiciclo;

  localparam logic [3:0] T_INIT = 4'd0,  T_F    = 4'd1,  T_D    = 4'd2;
  localparam logic [3:0] T_EX   = 4'd3,  T_WB   = 4'd4,  T_MA   = 4'd5;
  localparam logic [3:0] T_MR   = 4'd6,  T_MWB  = 4'd7,  T_MW   = 4'd8;
  localparam logic [3:0] T_BR   = 4'd9,  T_J    = 4'd10, T_H    = 4'd11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] Opcode = 3'b000;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegWrite, MemtoReg, ULASrcA, ForcaSub, Halted, Erro, Ilegal;
  logic [1:0] ULASrcB, ULAOp, PCSource;
  logic [3:0] Estado;

  logic [22:0] obs;
  logic [22:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  controle_multiciclo #(.WAIT_MAX(15), .CW(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ULAOp(ULAOp), .ForcaSub(ForcaSub),
    .PCSource(PCSource), .Halted(Halted), .Erro(Erro), .Ilegal(Ilegal), .Estado(Estado)
  );

  assign obs = {Estado, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegWrite, MemtoReg, ULASrcA, ULASrcB, ULAOp, ForcaSub, PCSource,
                Halted, Erro, Ilegal};

  // Expected outputs per state, taken from the state table
  function automatic logic [22:0] exp_out(input logic [3:0] st, input logic [2:0] op,
                                          input logic mr, input logic erro);
    logic pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, srca, fsub, hlt, ilg;
    logic [1:0] srcb, uop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, srca, fsub, hlt, ilg} = '0;
    {srcb, uop, pcs} = '0;
    case (st)
      T_F:   begin mrd = 1'b1; srcb = 2'b01; uop = 2'b10; irw = mr; pcw = mr; end
      T_D:   begin srcb = 2'b11; uop = 2'b10; ilg = (op == 3'b110); end
      T_EX:  begin srca = 1'b1; uop = {1'b0, op[0]}; end
      T_WB:  rw = 1'b1;
      T_MA:  begin srca = 1'b1; srcb = 2'b10; uop = 2'b11; end
      T_MR:  begin mrd = 1'b1; iord = 1'b1; end
      T_MWB: begin rw = 1'b1; m2r = 1'b1; end
      T_MW:  begin mwr = 1'b1; iord = 1'b1; end
      T_BR:  begin srca = 1'b1; fsub = 1'b1; pcwc = 1'b1; pcs = 2'b01; end
      T_J:   begin pcw = 1'b1; pcs = 2'b10; end
      T_H:   hlt = 1'b1;
      default: ;
    endcase
    return {st, pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, srca, srcb, uop, fsub, pcs,
            hlt, erro, ilg};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare at negedge
  task automatic step(input string tag, input logic chk, input logic rst,
                      input logic [3:0] st, input logic [2:0] op, input logic mr,
                      input logic erro);
    logic [22:0] e;
    string t;
    @(posedge clk);
    #1;
    reset     = rst;
    Opcode    = op;
    mem_ready = mr;
    Zero      = 1'($urandom_range(0, 1));
    if (chk) begin
      exp_q.push_back(exp_out(st, op, mr, erro));
      tag_q.push_back(tag);
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  initial begin
    step("rst0", 1'b0, 1'b1, T_INIT, 3'b000, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b1, T_INIT, 3'b000, 1'b0, 1'b0);
    step("init", 1'b1, 1'b0, T_INIT, 3'b000, 1'b1, 1'b0);

    step("add_f",  1'b1, 1'b0, T_F,  3'b000, 1'b1, 1'b0);
    step("add_d",  1'b1, 1'b0, T_D,  3'b000, 1'b1, 1'b0);
    step("add_ex", 1'b1, 1'b0, T_EX, 3'b000, 1'b1, 1'b0);
    step("add_wb", 1'b1, 1'b0, T_WB, 3'b000, 1'b1, 1'b0);

    step("slt_f",  1'b1, 1'b0, T_F,  3'b001, 1'b1, 1'b0);
    step("slt_d",  1'b1, 1'b0, T_D,  3'b001, 1'b0, 1'b0);
    step("slt_ex", 1'b1, 1'b0, T_EX, 3'b001, 1'b1, 1'b0);
    step("slt_wb", 1'b1, 1'b0, T_WB, 3'b001, 1'b0, 1'b0);

    step("lw_f",  1'b1, 1'b0, T_F,  3'b010, 1'b1, 1'b0);
    step("lw_d",  1'b1, 1'b0, T_D,  3'b010, 1'b1, 1'b0);
    step("lw_ma", 1'b1, 1'b0, T_MA, 3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lw_rd_wait", 1'b1, 1'b0, T_MR, 3'b010, 1'b0, 1'b0);
    step("lw_rd",  1'b1, 1'b0, T_MR,  3'b010, 1'b1, 1'b0);
    step("lw_mwb", 1'b1, 1'b0, T_MWB, 3'b010, 1'b1, 1'b0);

    step("sw_f",  1'b1, 1'b0, T_F,  3'b011, 1'b1, 1'b0);
    step("sw_d",  1'b1, 1'b0, T_D,  3'b011, 1'b1, 1'b0);
    step("sw_ma", 1'b1, 1'b0, T_MA, 3'b011, 1'b1, 1'b0);
    step("sw_wr", 1'b1, 1'b0, T_MW, 3'b011, 1'b1, 1'b0);

    step("beq_f",  1'b1, 1'b0, T_F,  3'b100, 1'b1, 1'b0);
    step("beq_d",  1'b1, 1'b0, T_D,  3'b100, 1'b1, 1'b0);
    step("beq_br", 1'b1, 1'b0, T_BR, 3'b100, 1'b1, 1'b0);

    step("j_f", 1'b1, 1'b0, T_F, 3'b101, 1'b1, 1'b0);
    step("j_d", 1'b1, 1'b0, T_D, 3'b101, 1'b1, 1'b0);
    step("j_j", 1'b1, 1'b0, T_J, 3'b101, 1'b1, 1'b0);

    step("ill_f", 1'b1, 1'b0, T_F, 3'b110, 1'b1, 1'b0);
    step("ill_d", 1'b1, 1'b0, T_D, 3'b110, 1'b1, 1'b0);

    for (int i = 0; i < 15; i++)
      step("late_f_wait", 1'b1, 1'b0, T_F, 3'b101, 1'b0, 1'b0);
    step("late_f_ready", 1'b1, 1'b0, T_F, 3'b101, 1'b1, 1'b0);
    step("late_d",       1'b1, 1'b0, T_D, 3'b101, 1'b0, 1'b0);
    step("late_j",       1'b1, 1'b0, T_J, 3'b101, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++)
      step("to_f_wait", 1'b1, 1'b0, T_F, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("to_halt", 1'b1, 1'b0, T_H, 3'b000, 1'b1, 1'b1);
    step("to_rst",  1'b1, 1'b1, T_H,    3'b000, 1'b0, 1'b1);
    step("to_init", 1'b1, 1'b0, T_INIT, 3'b000, 1'b0, 1'b0);

    step("halt_f", 1'b1, 1'b0, T_F, 3'b111, 1'b1, 1'b0);
    step("halt_d", 1'b1, 1'b0, T_D, 3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step("halt_hold", 1'b1, 1'b0, T_H, 3'b111, 1'(i % 2), 1'b0);
    step("halt_rst",  1'b1, 1'b1, T_H,    3'b111, 1'b0, 1'b0);
    step("halt_init", 1'b1, 1'b0, T_INIT, 3'b000, 1'b0, 1'b0);
    step("final_f",   1'b1, 1'b0, T_F,    3'b000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
